// File: rtl/uart_word_rx.sv
// UART receiver that assembles WORD_SIZE/WORD_PART frames, MSB byte first, into one word
// behind a valid/ready output register, with frame-error, overflow and idle-timeout pulses.
module uart_word_rx #(
  parameter int unsigned WORD_SIZE    = 32,
  parameter int unsigned WORD_PART    = 8,
  parameter int unsigned CLK_FREQ     = 200_000_000,
  parameter int unsigned BAUD_RATE    = 115200,
  parameter int unsigned TIMEOUT_BITS = 40
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sig_in,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 frame_err,
  output logic                 overflow,
  output logic                 timeout,
  output logic                 busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned NBYTES       = WORD_SIZE / WORD_PART;
  localparam int unsigned BYTE_W       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned BIT_W        = $clog2(WORD_PART + 1);
  localparam int unsigned TO_CYCLES    = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TO_W         = $clog2(TO_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]             warm_q, warm_d;
  logic                   line_high_q, line_high_d;
  logic [CNT_W-1:0]       clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]       bit_idx_q, bit_idx_d;
  logic [WORD_PART-1:0]   shift_q, shift_d;
  logic [WORD_SIZE-1:0]   word_q, word_d;
  logic [BYTE_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0]        idle_cnt_q, idle_cnt_d;
  logic [WORD_SIZE-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overflow_q, overflow_d;
  logic                   timeout_q, timeout_d;
  logic                   busy_q, busy_d;
  logic                   fall_c;

  // Falling edge only counts once the synchronizer holds real line samples and the line was high
  assign fall_c = line_high_q & ~sync2_q;

  always_comb begin
    state_d     = state_q;
    sync1_d     = sig_in;
    sync2_d     = sync1_q;
    warm_d      = {warm_q[0], 1'b1};
    line_high_d = warm_q[1] & sync2_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    word_d      = word_q;
    byte_cnt_d  = byte_cnt_q;
    idle_cnt_d  = '0;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overflow_d  = 1'b0;
    timeout_d   = 1'b0;

    if (valid_q && ready_in) valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fall_c) begin
          state_d   = S_START;
          clk_cnt_d = CNT_W'(HALF_BIT - 1);
        end else if (byte_cnt_q != '0) begin
          if (idle_cnt_q == TO_W'(TO_CYCLES - 1)) begin
            timeout_d  = 1'b1;
            byte_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + TO_W'(1);
          end
        end
      end
      S_START: begin
        if (clk_cnt_q == '0) begin
          if (!sync2_q) begin
            state_d   = S_DATA;
            clk_cnt_d = CNT_W'(CLKS_PER_BIT - 1);
            bit_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (clk_cnt_q == '0) begin
          shift_d   = {sync2_q, shift_q[WORD_PART-1:1]};
          clk_cnt_d = CNT_W'(CLKS_PER_BIT - 1);
          if (bit_idx_q == BIT_W'(WORD_PART - 1)) state_d = S_STOP;
          else bit_idx_d = bit_idx_q + BIT_W'(1);
        end else begin
          clk_cnt_d = clk_cnt_q - CNT_W'(1);
        end
      end
      S_STOP: begin
        if (clk_cnt_q == '0) begin
          state_d = S_IDLE;
          if (sync2_q) begin
            word_d = (word_q << WORD_PART) | WORD_SIZE'(shift_q);
            if (byte_cnt_q == BYTE_W'(NBYTES - 1)) begin
              byte_cnt_d = '0;
              if (!valid_q || ready_in) begin
                data_d  = word_d;
                valid_d = 1'b1;
              end else begin
                overflow_d = 1'b1;
              end
            end else begin
              byte_cnt_d = byte_cnt_q + BYTE_W'(1);
            end
          end else begin
            frame_err_d = 1'b1;
            byte_cnt_d  = '0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) || (byte_cnt_d != '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      warm_q      <= '0;
      line_high_q <= 1'b0;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      word_q      <= '0;
      byte_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      warm_q      <= warm_d;
      line_high_q <= line_high_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      word_q      <= word_d;
      byte_cnt_q  <= byte_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;
  assign timeout   = timeout_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_word_rx.sv
// Scoreboard bench for uart_word_rx at 16 clocks per bit: expected words are queued
// when sent and compared as the DUT hands them over.
module tb_uart_word_rx;

  localparam int unsigned CPB = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        sig_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic        ready_in;
  logic        frame_err;
  logic        overflow;
  logic        timeout;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int rx_cnt   = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int to_cnt   = 0;
  logic [31:0] exp_q[$];

  uart_word_rx #(
    .WORD_SIZE(32), .WORD_PART(8), .CLK_FREQ(16), .BAUD_RATE(1), .TIMEOUT_BITS(40)
  ) dut (
    .clock(clock), .reset(reset), .sig_in(sig_in), .data_out(data_out),
    .valid_out(valid_out), .ready_in(ready_in), .frame_err(frame_err),
    .overflow(overflow), .timeout(timeout), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on each handshake and counts pulse cycles
  always @(negedge clock) begin
    if (!reset) begin
      if (valid_out && ready_in) begin
        rx_cnt++;
        if (exp_q.size() > 0) check_eq("word", data_out, exp_q.pop_front());
        else check_eq("spurious_word_q_size", 32'(exp_q.size()), 32'd1);
      end
      if (frame_err) fe_cnt++;
      if (overflow)  ov_cnt++;
      if (timeout)   to_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sig_in = b;
    tick(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8], 1'b1);
  endtask

  initial begin
    int fe0, ov0, to0, rx0;
    reset = 1'b1; sig_in = 1'b1; ready_in = 1'b1;
    tick(3);
    @(negedge clock);
    check_eq("rst_data", data_out, 32'h0);
    check_eq("rst_valid", 32'(valid_out), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_fe", 32'(frame_err), 32'd0);
    check_eq("rst_ov", 32'(overflow), 32'd0);
    check_eq("rst_to", 32'(timeout), 32'd0);
    reset = 1'b0;
    tick(5);

    // Basic word, consumer always ready
    rx0 = rx_cnt;
    exp_q.push_back(32'hDEADBEEF);
    send_word(32'hDEADBEEF);
    tick(4);
    check_eq("basic_rx_count", 32'(rx_cnt - rx0), 32'd1);
    check_eq("basic_drained", 32'(exp_q.size()), 32'd0);

    // Back-pressure: second word dropped with overflow
    ready_in = 1'b0;
    ov0 = ov_cnt;
    exp_q.push_back(32'h01020304);
    send_word(32'h01020304);
    send_word(32'h05060708);
    tick(4);
    check_eq("ovf_pulse", 32'(ov_cnt - ov0), 32'd1);
    check_eq("ovf_valid_held", 32'(valid_out), 32'd1);
    check_eq("ovf_data_held", data_out, 32'h01020304);
    ready_in = 1'b1;
    tick(1);
    check_eq("ovf_valid_drop", 32'(valid_out), 32'd0);
    tick(4);

    // Frame error discards partial word
    fe0 = fe_cnt;
    send_byte(8'h99, 1'b1);
    send_byte(8'h11, 1'b0);
    sig_in = 1'b1;
    tick(20);
    check_eq("fe_pulse", 32'(fe_cnt - fe0), 32'd1);
    check_eq("fe_busy_clear", 32'(busy), 32'd0);
    exp_q.push_back(32'hA1A2A3A4);
    send_word(32'hA1A2A3A4);
    tick(4);

    // Short low glitch on idle line
    fe0 = fe_cnt; ov0 = ov_cnt; to0 = to_cnt; rx0 = rx_cnt;
    tick(32);
    sig_in = 1'b0;
    tick(4);
    sig_in = 1'b1;
    tick(2);
    check_eq("glitch_busy_start", 32'(busy), 32'd1);
    tick(30);
    check_eq("glitch_busy_idle", 32'(busy), 32'd0);
    check_eq("glitch_pulses", 32'((fe_cnt - fe0) + (ov_cnt - ov0) + (to_cnt - to0)), 32'd0);
    check_eq("glitch_no_word", 32'(rx_cnt - rx0), 32'd0);

    // Idle timeout drops a partial word
    to0 = to_cnt;
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    check_eq("partial_busy", 32'(busy), 32'd1);
    tick(CPB * 42);
    check_eq("to_pulse", 32'(to_cnt - to0), 32'd1);
    check_eq("to_busy_clear", 32'(busy), 32'd0);
    exp_q.push_back(32'h10203040);
    send_word(32'h10203040);
    tick(4);

    // Reset in the middle of the third byte, line still low at release
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    sig_in = 1'b0;
    tick(CPB * 4);
    reset = 1'b1;
    @(negedge clock);
    check_eq("midrst_data", data_out, 32'h0);
    check_eq("midrst_valid", 32'(valid_out), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    tick(20);
    reset = 1'b0;
    tick(50);
    check_eq("postrst_low_busy", 32'(busy), 32'd0);
    sig_in = 1'b1;
    tick(CPB * 3);
    check_eq("postrst_high_busy", 32'(busy), 32'd0);
    exp_q.push_back(32'hCAFEF00D);
    send_word(32'hCAFEF00D);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick(1);
    check_eq("drain", 32'(exp_q.size()), 32'd0);
    check_eq("no_stray_fe", 32'(fe_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
